// File: rtl/bf16_sigmoid_range_classify.sv
// bf16_sigmoid_range_classify
// Input stage of the bf16 sigmoid pipeline. It splits each bf16 operand into
// sign and magnitude and classifies the magnitude into a unit segment (0..5),
// a saturation region (6, |x| >= 6 including inf) or NaN (7). Results travel
// through a two-entry elastic pipeline (S1 -> S2). The block also keeps a
// saturating debug count of accepted saturated and NaN operands.
//
// Build option: define BF16_SIGMOID_FTZ_EN to flush subnormal operands to a
// zero magnitude (segment 0, sign kept). Without it, subnormals pass through
// unchanged and still classify as segment 0.

module bf16_sigmoid_range_classify #(
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [15:0]          out_abs,
    output logic [2:0]           out_seg,
    output logic                 out_sat,
    output logic                 out_nan,
    input  logic                 cnt_clear,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    // Segment thresholds 1.0 .. 6.0 as 15-bit magnitudes; slot 0 holds 1.0.
    // For non-NaN bf16 values the unsigned magnitude compare is monotonic in |x|.
    localparam int NUM_THRESH = 6;
    localparam logic [NUM_THRESH*15-1:0] THRESH_VEC = {
        15'h40C0,   // 6.0
        15'h40A0,   // 5.0
        15'h4080,   // 4.0
        15'h4040,   // 3.0
        15'h4000,   // 2.0
        15'h3F80    // 1.0
    };

    localparam logic [SAT_CNT_W-1:0] CNT_ONE = {{(SAT_CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Operand field split
    // ------------------------------------------------------------------
    logic        in_sign;
    logic [14:0] in_mag;
    logic [7:0]  in_exp;
    logic [6:0]  in_man;
    logic        in_is_nan;

    assign in_sign   = in_data[15];
    assign in_mag    = in_data[14:0];
    assign in_exp    = in_data[14:7];
    assign in_man    = in_data[6:0];
    assign in_is_nan = (in_exp == 8'hFF) && (in_man != 7'd0);

    // ------------------------------------------------------------------
    // Thermometer of "magnitude >= threshold"; upper boundary wins
    // ------------------------------------------------------------------
    logic [NUM_THRESH-1:0] ge_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THRESH; gi++) begin : g_thresh
            assign ge_vec[gi] = (in_mag >= THRESH_VEC[gi*15 +: 15]);
        end
    endgenerate

    logic [2:0]  cls_seg_next;
    logic [15:0] cls_abs_next;
    logic        cls_hit_next;

    // Segment index = highest threshold reached; NaN overrides everything.
    always_comb begin
        cls_seg_next = 3'd0;
        for (int i = 0; i < NUM_THRESH; i++) begin
            if (ge_vec[i]) begin
                cls_seg_next = 3'(i + 1);
            end
        end
        if (in_is_nan) begin
            cls_seg_next = 3'd7;
        end
    end

`ifdef BF16_SIGMOID_FTZ_EN
    logic in_is_sub;
    assign in_is_sub    = (in_exp == 8'h00) && (in_man != 7'd0);
    // Subnormals collapse to +0 magnitude; their segment is already 0.
    assign cls_abs_next = in_is_sub ? 16'h0000 : {1'b0, in_mag};
`else
    assign cls_abs_next = {1'b0, in_mag};
`endif

    // Segments 6 and 7 are exactly the codes with both upper bits set.
    assign cls_hit_next = cls_seg_next[2] & cls_seg_next[1];

    // ------------------------------------------------------------------
    // Elastic two-stage pipeline
    // ------------------------------------------------------------------
    logic        s1_valid_reg;
    logic        s1_sign_reg;
    logic [15:0] s1_abs_reg;
    logic [2:0]  s1_seg_reg;

    logic        s2_valid_reg;
    logic        s2_sign_reg;
    logic [15:0] s2_abs_reg;
    logic [2:0]  s2_seg_reg;

    logic        s2_load;
    logic        s1_load;
    logic        in_fire;

    // S2 frees up when empty or its entry is being taken; S1 frees up when
    // empty or its entry moves into S2. This gives full rate without bubbles.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = !rst && s1_load;
    assign in_fire  = in_valid && in_ready;

    // S1: capture the classification of an accepted operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_abs_reg   <= 16'h0000;
            s1_seg_reg   <= 3'd0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= in_sign;
                s1_abs_reg  <= cls_abs_next;
                s1_seg_reg  <= cls_seg_next;
            end
        end
    end

    // S2: output register; payload only changes when a real entry moves in,
    // so the outputs stay put while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_abs_reg   <= 16'h0000;
            s2_seg_reg   <= 3'd0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sign_reg <= s1_sign_reg;
                s2_abs_reg  <= s1_abs_reg;
                s2_seg_reg  <= s1_seg_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_sign  = s2_sign_reg;
    assign out_abs   = s2_abs_reg;
    assign out_seg   = s2_seg_reg;
    assign out_sat   = (s2_seg_reg == 3'd6);
    assign out_nan   = (s2_seg_reg == 3'd7);

    // ------------------------------------------------------------------
    // Saturated/NaN event counter (debug)
    // ------------------------------------------------------------------
    logic [SAT_CNT_W-1:0] sat_cnt_reg;
    logic                 sat_cnt_full;

    assign sat_cnt_full = &sat_cnt_reg;

    // Count accepted saturated/NaN operands; clear wins, no wrap at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_reg <= '0;
        end else if (cnt_clear) begin
            sat_cnt_reg <= '0;
        end else if (in_fire && cls_hit_next && !sat_cnt_full) begin
            sat_cnt_reg <= sat_cnt_reg + CNT_ONE;
        end
    end

    assign sat_cnt = sat_cnt_reg;

endmodule

// File: tb/tb_bf16_sigmoid_range_classify.sv
// Testbench for bf16_sigmoid_range_classify: directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
// Honours BF16_SIGMOID_FTZ_EN for the expected subnormal magnitude.

module tb_bf16_sigmoid_range_classify;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [15:0] out_abs;
    logic [2:0]  out_seg;
    logic        out_sat;
    logic        out_nan;
    logic        cnt_clear;
    logic [15:0] sat_cnt;

    // Second instance with a 2-bit counter for the saturation test.
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_sign;
    logic [15:0] b_out_abs;
    logic [2:0]  b_out_seg;
    logic        b_out_sat;
    logic        b_out_nan;
    logic        b_cnt_clear;
    logic [1:0]  b_sat_cnt;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    bf16_sigmoid_range_classify #(.SAT_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_abs(out_abs), .out_seg(out_seg),
        .out_sat(out_sat), .out_nan(out_nan),
        .cnt_clear(cnt_clear), .sat_cnt(sat_cnt)
    );

    bf16_sigmoid_range_classify #(.SAT_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sign(b_out_sign), .out_abs(b_out_abs), .out_seg(b_out_seg),
        .out_sat(b_out_sat), .out_nan(b_out_nan),
        .cnt_clear(b_cnt_clear), .sat_cnt(b_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc_n);
        end
    endtask

    // Reference classification from the numeric value of the operand.
    function automatic int model_seg(input logic [15:0] d);
        int  e;
        int  m;
        real v;
        e = int'(d[14:7]);
        m = int'(d[6:0]);
        if (e == 255) return (m != 0) ? 7 : 6;
        if (e == 0) return 0;               // zero and subnormals are tiny
        v = 1.0 + real'(m) / 128.0;
        for (int k = 127; k < e; k++) v = v * 2.0;
        for (int k = e; k < 127; k++) v = v / 2.0;
        if (v >= 6.0) return 6;
        return $rtoi(v);
    endfunction

    function automatic logic [15:0] model_abs(input logic [15:0] d);
`ifdef BF16_SIGMOID_FTZ_EN
        if (d[14:7] == 8'h00 && d[6:0] != 7'h00) return 16'h0000;
`endif
        return {1'b0, d[14:0]};
    endfunction

    typedef struct {
        logic        sign;
        logic [15:0] abs_v;
        int          seg;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   m_cnt = 0;
    logic mon_exp_valid;

    // Per-cycle compare against the model, then advance the model past the edge.
    always @(negedge clk) begin
        if (rst) begin
            lit("in_ready_in_reset", in_ready, 0);
            q.delete();
            m_cnt = 0;
        end else begin
            mon_exp_valid = (q.size() > 0) && (cyc_n >= q[0].acc + 2);
            lit("out_valid", out_valid, mon_exp_valid);
            lit("in_ready", in_ready, (q.size() < 2) || out_ready);
            lit("sat_cnt", sat_cnt, m_cnt);
            if (out_valid && mon_exp_valid) begin
                lit("out_sign", out_sign, q[0].sign);
                lit("out_abs", out_abs, q[0].abs_v);
                lit("out_seg", out_seg, q[0].seg);
                lit("out_sat", out_sat, q[0].seg == 6);
                lit("out_nan", out_nan, q[0].seg == 7);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (cnt_clear) begin
                m_cnt = 0;
            end else if (in_valid && in_ready && model_seg(in_data) >= 6 && m_cnt < 65535) begin
                m_cnt = m_cnt + 1;
            end
            if (in_valid && in_ready) begin
                mon_e.sign  = in_data[15];
                mon_e.abs_v = model_abs(in_data);
                mon_e.seg   = model_seg(in_data);
                mon_e.acc   = cyc_n;
                q.push_back(mon_e);
            end
        end
    end

    // One cycle on the main instance; returns at the following negedge.
    task automatic cyc_drive(input logic v, input logic [15:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic v, input logic [15:0] d, input logic clr);
        @(posedge clk);
        #1;
        b_in_valid  = v;
        b_in_data   = d;
        b_cnt_clear = clr;
        @(negedge clk);
    endtask

    logic [15:0] items [3];
    logic [15:0] sweep [13];
    logic [15:0] cur;
    int idx;
    int n_out;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1; cnt_clear = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'h0; b_out_ready = 1'b1; b_cnt_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        // Reset state
        lit("rst_out_valid", out_valid, 0);
        lit("rst_out_sign", out_sign, 0);
        lit("rst_out_abs", out_abs, 16'h0000);
        lit("rst_out_seg", out_seg, 0);
        lit("rst_out_sat", out_sat, 0);
        lit("rst_out_nan", out_nan, 0);
        lit("rst_sat_cnt", sat_cnt, 0);
        lit("rst_in_ready", in_ready, 1);

        // Segment boundaries around 1.0, back-to-back
        cyc_drive(1, 16'h3FC0, 1);
        cyc_drive(1, 16'h3F7F, 1);
        lit("t1_latency_not_yet", out_valid, 0);
        cyc_drive(1, 16'h3F80, 1);
        lit("t1_v0", out_valid, 1); lit("t1_seg0", out_seg, 1);
        lit("t1_abs0", out_abs, 16'h3FC0); lit("t1_sign0", out_sign, 0);
        cyc_drive(0, 16'h0, 1);
        lit("t1_seg1", out_seg, 0); lit("t1_abs1", out_abs, 16'h3F7F);
        cyc_drive(0, 16'h0, 1);
        lit("t1_seg2", out_seg, 1); lit("t1_abs2", out_abs, 16'h3F80);
        cyc_drive(0, 16'h0, 1);
        lit("t1_drained", out_valid, 0);

        // Segment 5, saturation, -inf and NaN with counter
        cyc_drive(1, 16'hC0A0, 1);
        cyc_drive(1, 16'h40C0, 1);
        cyc_drive(1, 16'hFF80, 1);
        lit("t2_seg_a", out_seg, 5); lit("t2_sign_a", out_sign, 1);
        lit("t2_abs_a", out_abs, 16'h40A0); lit("t2_sat_a", out_sat, 0);
        cyc_drive(1, 16'h7FC1, 1);
        lit("t2_seg_b", out_seg, 6); lit("t2_sat_b", out_sat, 1);
        lit("t2_sign_b", out_sign, 0); lit("t2_cnt_b", sat_cnt, 2);
        cyc_drive(0, 16'h0, 1);
        lit("t2_seg_c", out_seg, 6); lit("t2_sat_c", out_sat, 1);
        lit("t2_sign_c", out_sign, 1); lit("t2_abs_c", out_abs, 16'h7F80);
        lit("t2_cnt_c", sat_cnt, 3);
        cyc_drive(0, 16'h0, 1);
        lit("t3_seg_nan", out_seg, 7); lit("t3_nan", out_nan, 1);
        lit("t3_sat", out_sat, 0); lit("t3_abs", out_abs, 16'h7FC1);

        // Counter clear
        @(posedge clk); #1 cnt_clear = 1'b1;
        @(posedge clk); #1 cnt_clear = 1'b0;
        @(negedge clk);
        lit("clear_cnt", sat_cnt, 0);

        // Negative subnormal
        cyc_drive(1, 16'h8001, 1);
        cyc_drive(0, 16'h0, 1);
        cyc_drive(0, 16'h0, 1);
        lit("sub_valid", out_valid, 1);
        lit("sub_sign", out_sign, 1);
        lit("sub_seg", out_seg, 0);
`ifdef BF16_SIGMOID_FTZ_EN
        lit("sub_abs", out_abs, 16'h0000);
`else
        lit("sub_abs", out_abs, 16'h0001);
`endif
        cyc_drive(0, 16'h0, 1);

        // Stall with three operands offered
        items[0] = 16'h4040; items[1] = 16'h4080; items[2] = 16'h3E00;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            cur = items[idx];
            cyc_drive(1, cur, 0);
            if (in_ready) idx++;
        end
        lit("stall_accepted", idx, 2);
        lit("stall_in_ready", in_ready, 0);
        lit("stall_out_valid", out_valid, 1);
        lit("stall_out_abs", out_abs, 16'h4040);
        lit("stall_out_seg", out_seg, 3);
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            cur = items[(idx < 3) ? idx : 0];
            cyc_drive(idx < 3, cur, 1);
            if (k == 0) lit("release_in_ready", in_ready, 1);
            if (idx < 3 && in_ready) idx++;
            if (out_valid) n_out++;
        end
        lit("release_all_accepted", idx, 3);
        lit("release_all_out", n_out, 3);

        // Reset with two entries in flight
        cyc_drive(1, 16'h4040, 0);
        cyc_drive(1, 16'h40C1, 0);
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        lit("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        lit("midrst_out_valid", out_valid, 0);
        lit("midrst_in_ready_after", in_ready, 1);
        lit("midrst_cnt", sat_cnt, 0);
        repeat (3) cyc_drive(0, 16'h0, 1);
        lit("midrst_nothing_emitted", out_valid, 0);

        // Sweep across every segment with an irregular out_ready pattern
        sweep[0] = 16'h0000; sweep[1] = 16'h8000; sweep[2] = 16'h0080;
        sweep[3] = 16'h403F; sweep[4] = 16'h407F; sweep[5] = 16'h409F;
        sweep[6] = 16'h40BF; sweep[7] = 16'h40C1; sweep[8] = 16'h7F7F;
        sweep[9] = 16'hFFC0; sweep[10] = 16'h7F81; sweep[11] = 16'hBF80;
        sweep[12] = 16'h4000;
        idx = 0;
        for (int k = 0; k < 60 && idx < 13; k++) begin
            cur = sweep[idx];
            cyc_drive(1, cur, (k % 3) != 0);
            if (in_ready) idx++;
        end
        lit("sweep_all_accepted", idx, 13);
        repeat (4) cyc_drive(0, 16'h0, 1);
        lit("sweep_drained", q.size(), 0);

        // 2-bit counter saturates at 3; clear beats a simultaneous increment
        for (int i = 0; i < 5; i++) begin
            cyc_b(1, (i % 2 == 0) ? 16'h7F80 : 16'hC100, 0);
            lit("b_cnt_ramp", b_sat_cnt, (i < 3) ? i : 3);
            lit("b_in_ready", b_in_ready, 1);
        end
        cyc_b(0, 16'h0, 0);
        lit("b_cnt_hold", b_sat_cnt, 3);
        cyc_b(1, 16'h40C0, 1);
        cyc_b(0, 16'h0, 0);
        lit("b_cnt_clear_wins", b_sat_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
